// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and the datapath muxes it steers.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXE_R   = 4'd2;
    localparam logic [3:0] S_WB_R    = 4'd3;
    localparam logic [3:0] S_EXE_I   = 4'd4;
    localparam logic [3:0] S_WB_I    = 4'd5;
    localparam logic [3:0] S_MEM_ADR = 4'd6;
    localparam logic [3:0] S_MEM_RD  = 4'd7;
    localparam logic [3:0] S_MEM_WB  = 4'd8;
    localparam logic [3:0] S_MEM_WR  = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_RALU,
        CLS_IALU,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP
    } instrClass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational classifier: maps IR op/funct to an instruction class plus the
// execute-step ALU/extender settings and the jump flavour.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    output instrClass_t cls_o,
    output logic [2:0]  aluOp_o,
    output logic [1:0]  extOp_o,
    output logic        isStore_o,
    output logic        isLink_o,
    output logic [1:0]  jumpNpc_o
);

    always_comb begin
        cls_o     = CLS_ILLEGAL;
        aluOp_o   = ALU_ADD;
        extOp_o   = EXT_ZERO;
        isStore_o = 1'b0;
        isLink_o  = 1'b0;
        jumpNpc_o = NPC_JUMP;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: begin cls_o = CLS_RALU; aluOp_o = ALU_ADD; end
                    FN_SUBU: begin cls_o = CLS_RALU; aluOp_o = ALU_SUB; end
                    FN_AND:  begin cls_o = CLS_RALU; aluOp_o = ALU_AND; end
                    FN_OR:   begin cls_o = CLS_RALU; aluOp_o = ALU_OR;  end
                    FN_SLT:  begin cls_o = CLS_RALU; aluOp_o = ALU_SLT; end
                    FN_JR:   begin cls_o = CLS_JUMP; jumpNpc_o = NPC_REG; end
                    default: cls_o = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:   begin cls_o = CLS_IALU; aluOp_o = ALU_OR;  extOp_o = EXT_ZERO; end
            OP_ADDIU: begin cls_o = CLS_IALU; aluOp_o = ALU_ADD; extOp_o = EXT_SIGN; end
            // lui relies on rs=$0 so that add passes the shifted immediate through
            OP_LUI:   begin cls_o = CLS_IALU; aluOp_o = ALU_ADD; extOp_o = EXT_LUI;  end
            OP_LW:    cls_o = CLS_MEM;
            OP_SW:    begin cls_o = CLS_MEM; isStore_o = 1'b1; end
            OP_BEQ:   cls_o = CLS_BRANCH;
            OP_J:     cls_o = CLS_JUMP;
            OP_JAL:   begin cls_o = CLS_JUMP; isLink_o = 1'b1; end
            default:  cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives all datapath enables and selects, and counts retired instructions.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        dm_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        gpr_we,
    output logic        dm_we,
    output logic        dm_re,
    output logic [1:0]  npc_sel,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic [1:0]  ext_op,
    output logic        alu_bsel,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    logic [3:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        retire;

    instrClass_t decCls;
    logic [2:0]  decAluOp;
    logic [1:0]  decExtOp;
    logic        decIsStore;
    logic        decIsLink;
    logic [1:0]  decJumpNpc;

    ctrl_decode uDecode (
        .op_i      (op),
        .funct_i   (funct),
        .cls_o     (decCls),
        .aluOp_o   (decAluOp),
        .extOp_o   (decExtOp),
        .isStore_o (decIsStore),
        .isLink_o  (decIsLink),
        .jumpNpc_o (decJumpNpc)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (decCls)
                    CLS_RALU:   state_d = S_EXE_R;
                    CLS_IALU:   state_d = S_EXE_I;
                    CLS_MEM:    state_d = S_MEM_ADR;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    default:    state_d = S_FETCH;
                endcase
            end
            S_EXE_R:   state_d = S_WB_R;
            S_EXE_I:   state_d = S_WB_I;
            S_MEM_ADR: state_d = decIsStore ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (dm_ready) state_d = S_MEM_WB;
            S_MEM_WR: begin
                if (dm_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced to zero while reset is held so an aborted access never fires
    always_comb begin
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        gpr_we   = 1'b0;
        dm_we    = 1'b0;
        dm_re    = 1'b0;
        npc_sel  = NPC_PC4;
        reg_dst  = REGDST_RT;
        wd_sel   = WD_ALU;
        ext_op   = EXT_ZERO;
        alu_bsel = 1'b0;
        alu_op   = ALU_ADD;
        illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                S_DECODE: illegal = (decCls == CLS_ILLEGAL);
                S_EXE_R:  alu_op = decAluOp;
                S_WB_R: begin
                    gpr_we  = 1'b1;
                    reg_dst = REGDST_RD;
                end
                S_EXE_I: begin
                    alu_bsel = 1'b1;
                    ext_op   = decExtOp;
                    alu_op   = decAluOp;
                end
                S_WB_I: gpr_we = 1'b1;
                S_MEM_ADR: begin
                    alu_bsel = 1'b1;
                    ext_op   = EXT_SIGN;
                end
                S_MEM_RD: dm_re = 1'b1;
                S_MEM_WB: begin
                    gpr_we = 1'b1;
                    wd_sel = WD_DM;
                end
                S_MEM_WR: dm_we = 1'b1;
                S_BRANCH: begin
                    alu_op  = ALU_SUB;
                    npc_sel = NPC_BRANCH;
                    pc_we   = zero;
                end
                S_JUMP: begin
                    pc_we   = 1'b1;
                    npc_sel = decJumpNpc;
                    if (decIsLink) begin
                        gpr_we  = 1'b1;
                        reg_dst = REGDST_RA;
                        wd_sel  = WD_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_cnt = rst ? 32'd0 : cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: an instruction-level model predicts the
// per-cycle control vector, a monitor compares it against the DUT mid-cycle.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic        pcWe;
        logic        irWe;
        logic        gprWe;
        logic        dmWe;
        logic        dmRe;
        logic [1:0]  npcSel;
        logic [1:0]  regDst;
        logic [1:0]  wdSel;
        logic [1:0]  extOp;
        logic        aluBsel;
        logic [2:0]  aluOp;
        logic        illegal;
        logic [31:0] cnt;
    } ctrlVec_t;

    localparam int K_ILLEGAL = 0;
    localparam int K_R       = 1;
    localparam int K_ORI     = 2;
    localparam int K_ADDIU   = 3;
    localparam int K_LUI     = 4;
    localparam int K_LW      = 5;
    localparam int K_SW      = 6;
    localparam int K_BEQ     = 7;
    localparam int K_J       = 8;
    localparam int K_JAL     = 9;
    localparam int K_JR      = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        dm_ready;
    logic        pc_we, ir_we, gpr_we, dm_we, dm_re, alu_bsel, illegal;
    logic [1:0]  npc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0]  alu_op;
    logic [31:0] instr_cnt;

    ctrlVec_t    expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] modelCnt;
    bit          aborted;
    int          cycleIdx;
    int          abortAt;

    logic [5:0]  legalOp[14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'b001101, 6'b001001, 6'b001111, 6'b100011,
                                 6'b101011, 6'b000100, 6'b000010, 6'b000011};
    logic [5:0]  legalFn[14] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                 6'b101010, 6'b001000, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    mips_mc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .dm_ready  (dm_ready),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .gpr_we    (gpr_we),
        .dm_we     (dm_we),
        .dm_re     (dm_re),
        .npc_sel   (npc_sel),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .ext_op    (ext_op),
        .alu_bsel  (alu_bsel),
        .alu_op    (alu_op),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000) begin
            case (f)
                6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010: return K_R;
                6'b001000: return K_JR;
                default:   return K_ILLEGAL;
            endcase
        end
        case (o)
            6'b001101: return K_ORI;
            6'b001001: return K_ADDIU;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILLEGAL;
        endcase
    endfunction

    function automatic logic [2:0] rAluOp(input logic [5:0] f);
        case (f)
            6'b100011: return 3'b001;
            6'b100100: return 3'b010;
            6'b100101: return 3'b011;
            6'b101010: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    task automatic applyStimulus(input ctrlVec_t exp, input logic rstV, input logic dmr, input logic z);
        rst      = rstV;
        dm_ready = dmr;
        zero     = z;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    // One model cycle; a scheduled abort turns it into a reset cycle with all-zero outputs
    task automatic emit(input ctrlVec_t v, input logic dmr, input logic z);
        ctrlVec_t e;
        if (aborted) return;
        if (cycleIdx == abortAt) begin
            e = '0;
            applyStimulus(e, 1'b1, dmr, z);
            modelCnt = '0;
            aborted  = 1'b1;
        end else begin
            e     = v;
            e.cnt = modelCnt;
            applyStimulus(e, 1'b0, dmr, z);
        end
        cycleIdx++;
    endtask

    task automatic retireModel();
        if (!aborted) modelCnt = modelCnt + 32'd1;
    endtask

    task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input int waits,
                            input int zsel, input int abortIdx);
        ctrlVec_t v;
        int       kind;
        logic     z;
        op       = o;
        funct    = f;
        aborted  = 1'b0;
        cycleIdx = 0;
        abortAt  = abortIdx;
        kind     = classify(o, f);

        v = '0; v.pcWe = 1'b1; v.irWe = 1'b1;
        emit(v, rb(), rb());
        v = '0; v.illegal = (kind == K_ILLEGAL);
        emit(v, rb(), rb());
        if (kind == K_ILLEGAL) return;

        case (kind)
            K_R: begin
                v = '0; v.aluOp = rAluOp(f);
                emit(v, rb(), rb());
                v = '0; v.gprWe = 1'b1; v.regDst = 2'b01;
                emit(v, rb(), rb());
            end
            K_ORI, K_ADDIU, K_LUI: begin
                v = '0; v.aluBsel = 1'b1;
                v.extOp = (kind == K_ORI) ? 2'b00 : (kind == K_ADDIU) ? 2'b01 : 2'b10;
                v.aluOp = (kind == K_ORI) ? 3'b011 : 3'b000;
                emit(v, rb(), rb());
                v = '0; v.gprWe = 1'b1;
                emit(v, rb(), rb());
            end
            K_LW, K_SW: begin
                v = '0; v.aluBsel = 1'b1; v.extOp = 2'b01;
                emit(v, rb(), rb());
                for (int i = 0; i <= waits; i++) begin
                    v = '0;
                    if (kind == K_LW) v.dmRe = 1'b1;
                    else v.dmWe = 1'b1;
                    emit(v, logic'(i == waits), rb());
                end
                if (kind == K_LW) begin
                    v = '0; v.gprWe = 1'b1; v.wdSel = 2'b01;
                    emit(v, rb(), rb());
                end
            end
            K_BEQ: begin
                z = (zsel == 2) ? rb() : logic'(zsel);
                v = '0; v.aluOp = 3'b001; v.npcSel = 2'b01; v.pcWe = z;
                emit(v, rb(), z);
            end
            default: begin
                v = '0; v.pcWe = 1'b1;
                v.npcSel = (kind == K_JR) ? 2'b11 : 2'b10;
                if (kind == K_JAL) begin
                    v.gprWe = 1'b1; v.regDst = 2'b10; v.wdSel = 2'b10;
                end
                emit(v, rb(), rb());
            end
        endcase
        retireModel();
    endtask

    task automatic checkOutput(input ctrlVec_t exp);
        ctrlVec_t act;
        act = '{pc_we, ir_we, gpr_we, dm_we, dm_re, npc_sel, reg_dst, wd_sel,
                ext_op, alu_bsel, alu_op, illegal, instr_cnt};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL ctrl vector %0d (op=%b funct=%b): got ctrl=%h cnt=%h, expected ctrl=%h cnt=%h",
                     vectors, op, funct, act[49:32], act.cnt, exp[49:32], exp.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired with %0d vectors checked", vectors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        ctrlVec_t zv;
        int       pick;
        logic [5:0] o, f;
        zv       = '0;
        rst      = 1'b1;
        op       = '0;
        funct    = '0;
        zero     = 1'b0;
        dm_ready = 1'b0;
        modelCnt = '0;
        @(posedge clk);
        #1;
        applyStimulus(zv, 1'b1, 1'b1, 1'b1);
        applyStimulus(zv, 1'b1, 1'b1, 1'b1);

        runInstr(6'b000000, 6'b100001, 0, 2, -1);   // addu
        runInstr(6'b100011, 6'b000000, 2, 2, -1);   // lw, two wait cycles
        runInstr(6'b000100, 6'b000000, 0, 1, -1);   // beq taken
        runInstr(6'b000100, 6'b000000, 0, 0, -1);   // beq not taken
        runInstr(6'b000011, 6'b000000, 0, 2, -1);   // jal
        runInstr(6'b111111, 6'b000000, 0, 2, -1);   // illegal
        runInstr(6'b101011, 6'b000000, 1, 2, -1);   // sw, one wait cycle

        for (int n = 0; n < 120; n++) begin
            pick = $urandom_range(0, 15);
            if (pick < 14) begin
                o = legalOp[pick];
                f = legalFn[pick];
            end else if (pick == 14) begin
                o = 6'($urandom_range(0, 63));
                f = 6'($urandom_range(0, 63));
            end else begin
                o = 6'b000000;
                f = 6'($urandom_range(0, 63));
            end
            runInstr(o, f, $urandom_range(0, 3), 2,
                     ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1);
        end

        // Counter wrap: hold the count at all-ones across a non-retiring instruction
        modelCnt = 32'hFFFF_FFFF;
        force dut.cnt_q = 32'hFFFF_FFFF;
        runInstr(6'b111111, 6'b000000, 0, 2, -1);
        release dut.cnt_q;
        runInstr(6'b000000, 6'b100101, 0, 2, -1);   // or retires, count wraps to 0
        runInstr(6'b001111, 6'b000000, 0, 2, -1);   // lui

        // Reset during a stalled store, then confirm a clean restart
        runInstr(6'b101011, 6'b000000, 3, 2, 3);
        runInstr(6'b000000, 6'b100001, 0, 2, -1);
        runInstr(6'b000000, 6'b001000, 0, 2, -1);   // jr

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
